// File: rtl/ws2812_rx_if.sv
// WS2812 receiver bundle: serial line in, captured frame and status out.
// The master side drives din; the slave (receiver) side owns frame results.
interface ws2812_rx_if #(
    parameter int NUM_LEDS = 16
);
    logic                      din;
    logic [24*NUM_LEDS-1:0]    packed_rgb_data;
    logic                      frame_valid;
    logic                      frame_error;
    logic                      busy;

    modport master (
        output din,
        input  packed_rgb_data, frame_valid, frame_error, busy
    );

    modport slave (
        input  din,
        output packed_rgb_data, frame_valid, frame_error, busy
    );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 serial decoder: captures NUM_LEDS 24-bit pixels per frame; the frame appears one cycle
// after the reset gap is recognised. No backpressure: frames are published or dropped, never stalled.
module ws2812_rx #(
    parameter int NUM_LEDS = 16,
    parameter int CLK_MHZ  = 12
) (
    input  logic         clk,
    input  logic         reset_n,
    ws2812_rx_if.slave   bus
);
    localparam int FRAME_BITS = 24 * NUM_LEDS;
    localparam int BW         = $clog2(FRAME_BITS + 1);
    localparam int T_BIT      = CLK_MHZ * 600 / 1000;
    localparam int T_HMAX     = CLK_MHZ * 2;
    localparam int T_RESET    = CLK_MHZ * 50;

    // The counter reads (pulse length - 1) in the cycle that observes the pulse ending.
    localparam logic [15:0]   BIT_LIM   = 16'(T_BIT - 1);
    localparam logic [15:0]   HMAX_LIM  = 16'(T_HMAX);
    localparam logic [15:0]   GAP_LIM   = 16'(T_RESET - 1);
    localparam logic [BW-1:0] FRAME_CNT = BW'(FRAME_BITS);
    localparam logic [BW-1:0] BIT_SAT   = BW'(FRAME_BITS + 1);
    localparam logic [BW-1:0] PIX_BITS  = BW'(24);

    typedef enum logic [2:0] {
        WAIT_GAP,
        IDLE,
        HIGH,
        LOW,
        DROP
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync2_q, sync3_q;
    logic [15:0]            cnt_q, cnt_d;
    logic [BW-1:0]          bitcnt_q, bitcnt_d;
    logic [FRAME_BITS-1:0]  shadow_q, shadow_d;
    logic [FRAME_BITS-1:0]  rgb_q, rgb_d;
    logic                   fv_q, fv_d;
    logic                   fe_q, fe_d;

    logic                   ds, ds_rise, ds_fall, gap_done;
    logic [BW-1:0]          wr_idx;

    assign ds      = sync2_q;
    assign ds_rise = sync2_q & ~sync3_q;
    assign ds_fall = ~sync2_q & sync3_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= WAIT_GAP;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shadow_q <= '0;
            rgb_q    <= '0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= bus.din;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shadow_q <= shadow_d;
            rgb_q    <= rgb_d;
            fv_q     <= fv_d;
            fe_q     <= fe_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shadow_d = shadow_q;
        rgb_d    = rgb_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;

        if (ds_rise || ds_fall) begin
            cnt_d = '0;
        end else if (cnt_q == 16'hFFFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end

        gap_done = ~ds && (cnt_q >= GAP_LIM);
        // Pixel-major, MSB-first placement of the current bit.
        wr_idx   = (bitcnt_q / PIX_BITS) * PIX_BITS
                 + (PIX_BITS - BW'(1) - (bitcnt_q % PIX_BITS));

        case (state_q)
            WAIT_GAP: begin
                if (gap_done) state_d = IDLE;
            end
            IDLE: begin
                if (ds_rise) begin
                    state_d  = HIGH;
                    bitcnt_d = '0;
                end
            end
            HIGH: begin
                if (ds_fall) begin
                    if (bitcnt_q < FRAME_CNT) shadow_d[wr_idx] = (cnt_q >= BIT_LIM);
                    if (bitcnt_q != BIT_SAT) bitcnt_d = bitcnt_q + BW'(1);
                    state_d = LOW;
                end else if (ds && (cnt_q >= HMAX_LIM)) begin
                    state_d = DROP;
                    fe_d    = 1'b1;
                end
            end
            LOW: begin
                if (ds_rise) begin
                    state_d = HIGH;
                end else if (gap_done) begin
                    state_d = IDLE;
                    if (bitcnt_q == FRAME_CNT) begin
                        rgb_d = shadow_q;
                        fv_d  = 1'b1;
                    end else begin
                        fe_d  = 1'b1;
                    end
                end
            end
            DROP: begin
                if (gap_done) state_d = IDLE;
            end
            default: state_d = WAIT_GAP;
        endcase
    end

    assign bus.packed_rgb_data = rgb_q;
    assign bus.frame_valid     = fv_q;
    assign bus.frame_error     = fe_q;
    assign bus.busy            = (state_q == HIGH) || (state_q == LOW);
endmodule

// File: doc/ws2812_rx.md
WS2812_RX -- requirements
Module: ws2812_rx

Interface
REQ-001 Parameter NUM_LEDS, default 16: number of 24-bit pixels captured per frame.
REQ-002 Parameter CLK_MHZ, default 12: clk frequency in MHz; all timing thresholds derive from it.
REQ-003 Port clk, input, 1: single clock, all state on rising edge.
REQ-004 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port din, input, 1: asynchronous WS2812 serial line, the same waveform ws2812 drives on data.
REQ-006 Port packed_rgb_data, output, 24*NUM_LEDS: last good frame, pixel i at [24*i +: 24], {green, red, blue}, same layout ws2812 consumes.
REQ-007 Port frame_valid, output, 1: one-cycle pulse when packed_rgb_data has just been updated.
REQ-008 Port frame_error, output, 1: one-cycle pulse when a frame is discarded.
REQ-009 Port busy, output, 1: high while in HIGH or LOW state.

Function
REQ-010 din passes through a 2-flop synchronizer; all decode uses the synchronized value (ds); ds rising/falling edges detected against a third registered copy.
REQ-011 Derived constants (integer division): T_BIT = CLK_MHZ*600/1000 (7 at 12 MHz); T_HMAX = CLK_MHZ*2 (24); T_RESET = CLK_MHZ*50 (600).
REQ-012 Single 16-bit pulse counter, saturating at all-ones, cleared on every ds edge, incremented otherwise.
REQ-013 States: WAIT_GAP, IDLE, HIGH, LOW, DROP.
REQ-014 WAIT_GAP (reset state): ds low for T_RESET consecutive cycles -> IDLE; any ds high clears the count; no bits captured.
REQ-015 IDLE: ds rising edge -> HIGH, bit counter cleared, shadow buffer not cleared.
REQ-016 HIGH: ds falling edge -> decide bit: high-time count >= T_BIT is 1, else 0 -> LOW; count exceeding T_HMAX while high -> DROP.
REQ-017 LOW: ds rising edge -> HIGH (next bit); low count reaching T_RESET -> end-of-frame.
REQ-018 Bit placement: bit k of frame (k from 0) written to shadow[24*(k/24) + 23 - (k%24)]; pixel 0 first, MSB first.
REQ-019 Bit counter width clog2(24*NUM_LEDS+1), saturates at 24*NUM_LEDS+1; bits with k >= 24*NUM_LEDS are not stored.
REQ-020 End-of-frame with exactly 24*NUM_LEDS bits: on the next clk edge shadow copied to packed_rgb_data and frame_valid pulses, same cycle; -> IDLE.
REQ-021 End-of-frame with any other bit count: frame_error pulses, packed_rgb_data unchanged, -> IDLE.
REQ-022 DROP: frame_error pulses on entry; remains until ds low for T_RESET cycles -> IDLE; packed_rgb_data unchanged.
REQ-023 frame_valid and frame_error never asserted in the same cycle; each is exactly one cycle wide.
REQ-024 packed_rgb_data changes only in the frame_valid cycle; partially received frames are never visible.

Reset
REQ-025 reset_n low: state WAIT_GAP, counters 0, synchronizer flops 0, shadow 0, packed_rgb_data 0, frame_valid 0, frame_error 0, busy 0, immediately and asynchronously.
REQ-026 reset_n deasserted mid-frame: block re-enters WAIT_GAP, no bits of that frame captured, no frame_valid for it.

Verification (CLK_MHZ=12, NUM_LEDS=16)
REQ-027 Reset, din low 600 cycles, 384 bits (0: 5 high/10 low, 1: 10 high/5 low) with pixel0=0x10_10_10, others 0x000000, then 600 low -> one frame_valid, packed_rgb_data[23:0]=0x101010, rest 0.
REQ-028 Threshold: bits of 6 high cycles decode 0, 7 high decode 1 (at din, accounting 2-cycle sync delay equally on both edges).
REQ-029 383-bit frame then gap -> frame_error single pulse, packed_rgb_data retains prior frame; 385-bit frame -> same.
REQ-030 High pulse of 30 cycles mid-frame -> frame_error, no frame_valid until a full 600-cycle gap and a complete new frame.
REQ-031 Begin driving mid-frame right after reset with no leading gap -> no capture until 600-cycle low gap; following complete frame decodes correctly.
REQ-032 Assert reset_n low during bit 200 -> outputs 0 immediately; after release, next complete frame yields frame_valid with correct data.
